// File: rtl/switch_input_pkg.sv
// Shared widths, event-code layout and the pending-mask priority helper.
package switch_input_pkg;

    localparam int unsigned NUM_SW      = 4;
    localparam int unsigned EVT_W       = 3;
    localparam int unsigned EVT_REL_BIT = 2;
    localparam int unsigned PEND_W      = 2 * NUM_SW;

    // Lowest set bit of the pending mask; press bits 0-3 win over release bits 4-7.
    function automatic logic [EVT_W-1:0] lowest_set(input logic [PEND_W-1:0] v);
        logic [EVT_W-1:0] idx;
        idx = '0;
        for (int i = PEND_W - 1; i >= 0; i--) begin
            if (v[i]) idx = EVT_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/switch_input_debounce_bit.sv
// Two-flop synchroniser plus counter debounce for one switch, with edge pulses.
module debounce_bit #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_Raw,
    output logic o_Level,
    output logic o_Rise,
    output logic o_Fall
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_q, meta_d;
    logic             sync_q, sync_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The counter only runs while the synced input disagrees with the level.
    always_comb begin
        meta_d  = i_Raw;
        sync_d  = meta_q;
        level_d = level_q;
        cnt_d   = '0;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync_q != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = sync_q;
                rise_d  = sync_q;
                fall_d  = ~sync_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            meta_q  <= meta_d;
            sync_q  <= sync_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_Level = level_q;
    assign o_Rise  = rise_q;
    assign o_Fall  = fall_q;

endmodule

// File: rtl/switch_input.sv
// Four debounced switches feeding a pending-mask event queue with valid/ready output.
module switch_input
    import switch_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic              i_Clk,
    input  logic              i_Reset,
    input  logic              i_Switch_1,
    input  logic              i_Switch_2,
    input  logic              i_Switch_3,
    input  logic              i_Switch_4,
    output logic [NUM_SW-1:0] o_Level,
    output logic [NUM_SW-1:0] o_Press,
    output logic [NUM_SW-1:0] o_Release,
    output logic              o_Event_Valid,
    output logic [EVT_W-1:0]  o_Event_Code,
    input  logic              i_Event_Ready,
    output logic              o_Overflow
);

    logic [NUM_SW-1:0] raw;
    logic [NUM_SW-1:0] rise;
    logic [NUM_SW-1:0] fall;

    assign raw = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

    for (genvar n = 0; n < NUM_SW; n++) begin : g_db
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .i_Clk  (i_Clk),
            .i_Reset(i_Reset),
            .i_Raw  (raw[n]),
            .o_Level(o_Level[n]),
            .o_Rise (rise[n]),
            .o_Fall (fall[n])
        );
    end

    assign o_Press   = rise;
    assign o_Release = fall;

    logic [PEND_W-1:0] pend_q, pend_d;
    logic              valid_q, valid_d;
    logic [EVT_W-1:0]  code_q, code_d;
    logic              ovf_q, ovf_d;
    logic [PEND_W-1:0] new_evt;
    logic [PEND_W-1:0] acc_mask;
    logic [PEND_W-1:0] pend_now;
    logic              accept;

    // Release pulses occupy the upper half so the code's top bit marks a release.
    always_comb begin
        new_evt  = {fall, rise};
        accept   = valid_q & i_Event_Ready;
        acc_mask = accept ? (PEND_W'(1) << code_q) : '0;
        pend_now = pend_q | new_evt;
        pend_d   = (pend_q & ~acc_mask) | new_evt;
        ovf_d    = ovf_q | (|(new_evt & pend_q & ~acc_mask));
        valid_d  = valid_q;
        code_d   = code_q;
        if (accept) begin
            valid_d = 1'b0;
        end else if (!valid_q && (|pend_now)) begin
            valid_d = 1'b1;
            code_d  = lowest_set(pend_now);
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            pend_q  <= '0;
            valid_q <= 1'b0;
            code_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            valid_q <= valid_d;
            code_q  <= code_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_Event_Valid = valid_q;
    assign o_Event_Code  = code_q;
    assign o_Overflow    = ovf_q;

endmodule

// File: tb/tb_switch_input.sv
// Randomised and directed bench for switch_input against a sample-window reference model.
module tb_switch_input;

    localparam int unsigned D    = 4;
    localparam int unsigned HLEN = D + 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sw;
    logic       ready;
    logic [3:0] o_level, o_press, o_release;
    logic       o_valid, o_ovf;
    logic [2:0] o_code;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    switch_input #(.DEBOUNCE_CYCLES(D)) dut (
        .i_Clk        (clk),
        .i_Reset      (rst),
        .i_Switch_1   (sw[0]),
        .i_Switch_2   (sw[1]),
        .i_Switch_3   (sw[2]),
        .i_Switch_4   (sw[3]),
        .o_Level      (o_level),
        .o_Press      (o_press),
        .o_Release    (o_release),
        .o_Event_Valid(o_valid),
        .o_Event_Code (o_code),
        .i_Event_Ready(ready),
        .o_Overflow   (o_ovf)
    );

    always #5 clk = ~clk;

    // Reference state: raw sample history per switch, pending set, presented event.
    bit   m_hist [4][HLEN];
    bit   m_lvl  [4];
    bit   m_press[4];
    bit   m_rel  [4];
    bit   m_pend [8];
    bit   m_valid;
    int   m_code;
    bit   m_ovf;

    int   acc_codes[$];
    int   acc_times[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_step();
        bit new_ev[8];
        bit any;
        bit accept;
        if (rst) begin
            for (int n = 0; n < 4; n++) begin
                for (int h = 0; h < HLEN; h++) m_hist[n][h] = 0;
                m_lvl[n] = 0; m_press[n] = 0; m_rel[n] = 0;
            end
            for (int b = 0; b < 8; b++) m_pend[b] = 0;
            m_valid = 0; m_code = 0; m_ovf = 0;
            return;
        end
        for (int n = 0; n < 4; n++) begin
            new_ev[n]     = m_press[n];
            new_ev[n + 4] = m_rel[n];
        end
        accept = m_valid && ready;
        for (int b = 0; b < 8; b++)
            if (new_ev[b] && m_pend[b] && !(accept && m_code == b)) m_ovf = 1;
        any = 0;
        for (int b = 0; b < 8; b++) any |= m_pend[b] | new_ev[b];
        if (accept) begin
            m_valid = 0;
        end else if (!m_valid && any) begin
            m_valid = 1;
            for (int b = 7; b >= 0; b--) if (m_pend[b] || new_ev[b]) m_code = b;
        end
        if (accept) m_pend[m_code] = 0;
        for (int b = 0; b < 8; b++) if (new_ev[b]) m_pend[b] = 1;
        // A flip needs D consecutive synced samples (raw two edges old) against the level.
        for (int n = 0; n < 4; n++) begin
            bit all_diff;
            for (int h = HLEN - 1; h > 0; h--) m_hist[n][h] = m_hist[n][h-1];
            m_hist[n][0] = sw[n];
            all_diff = 1;
            for (int h = 2; h <= D + 1; h++) if (m_hist[n][h] == m_lvl[n]) all_diff = 0;
            m_press[n] = 0; m_rel[n] = 0;
            if (all_diff) begin
                m_lvl[n]   = ~m_lvl[n];
                m_press[n] = m_lvl[n];
                m_rel[n]   = ~m_lvl[n];
            end
        end
    endtask

    task automatic compare_all();
        logic [3:0] el, ep, er;
        for (int n = 0; n < 4; n++) begin
            el[n] = m_lvl[n]; ep[n] = m_press[n]; er[n] = m_rel[n];
        end
        check("level",   32'(o_level),   32'(el));
        check("press",   32'(o_press),   32'(ep));
        check("release", 32'(o_release), 32'(er));
        check("valid",   32'(o_valid),   32'(m_valid));
        check("code",    32'(o_code),    32'(m_code));
        check("ovf",     32'(o_ovf),     32'(m_ovf));
    endtask

    task automatic cycle();
        if (o_valid && ready) begin
            acc_codes.push_back(int'(o_code));
            acc_times.push_back(cyc);
        end
        @(posedge clk);
        model_step();
        cyc++;
        @(negedge clk);
        compare_all();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic wait_press(input int bitn, output int edges);
        edges = -1;
        for (int i = 1; i <= 20; i++) begin
            cycle();
            if (o_press[bitn]) begin
                edges = i;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        bit seen;
        rst = 1'b1; sw = 4'b0; ready = 1'b0;
        run(3);
        check("rst_level", 32'(o_level), 32'h0);
        check("rst_valid", 32'(o_valid), 32'h0);
        rst = 1'b0;
        run(3);

        // Clean press of switch 2
        sw[1] = 1'b1;
        wait_press(1, lat);
        check("t1_latency", 32'(lat), 32'd6);
        check("t1_level", 32'(o_level), 32'h2);
        cycle();
        check("t1_valid", 32'(o_valid), 32'h1);
        check("t1_code", 32'(o_code), 32'h1);
        check("t1_pulse_1cyc", 32'(o_press), 32'h0);
        ready = 1'b1;
        cycle();
        check("t1_drop", 32'(o_valid), 32'h0);
        sw[1] = 1'b0;
        run(12);

        // Bounce shorter than the debounce window
        seen = 0;
        sw[0] = 1'b1; repeat (3) begin cycle(); seen |= o_press[0] | o_valid; end
        sw[0] = 1'b0; cycle(); seen |= o_press[0] | o_valid;
        sw[0] = 1'b1; repeat (3) begin cycle(); seen |= o_press[0] | o_valid; end
        sw[0] = 1'b0; repeat (8) begin cycle(); seen |= o_press[0] | o_valid; end
        check("t2_no_event", 32'(seen), 32'h0);
        check("t2_level", 32'(o_level), 32'h0);

        // Press then release switch 4, Ready tied high
        acc_codes.delete(); acc_times.delete();
        sw[3] = 1'b1; run(10);
        sw[3] = 1'b0; run(14);
        check("t3_count", 32'(acc_codes.size()), 32'd2);
        if (acc_codes.size() == 2) begin
            check("t3_first", 32'(acc_codes[0]), 32'd3);
            check("t3_second", 32'(acc_codes[1]), 32'd7);
        end

        // All four at once, consumer stalled then draining
        ready = 1'b0;
        sw = 4'hF; run(20);
        acc_codes.delete(); acc_times.delete();
        ready = 1'b1; run(12);
        check("t4_count", 32'(acc_codes.size()), 32'd4);
        if (acc_codes.size() == 4) begin
            for (int i = 0; i < 4; i++) check("t4_order", 32'(acc_codes[i]), 32'(i));
            for (int i = 1; i < 4; i++) check("t4_spacing", 32'(acc_times[i] - acc_times[i-1]), 32'd2);
        end
        check("t4_ovf", 32'(o_ovf), 32'h0);
        sw = 4'h0; run(20);

        // Press/release/press on switch 3 while stalled
        ready = 1'b0;
        sw[2] = 1'b1; run(10);
        sw[2] = 1'b0; run(10);
        check("t5_no_ovf_yet", 32'(o_ovf), 32'h0);
        sw[2] = 1'b1; run(10);
        check("t5_valid", 32'(o_valid), 32'h1);
        check("t5_code", 32'(o_code), 32'h2);
        check("t5_ovf", 32'(o_ovf), 32'h1);
        ready = 1'b1; run(10);
        sw[2] = 1'b0; run(14);

        // Reset mid-debounce with switch 1 held
        sw[0] = 1'b1; run(4);
        rst = 1'b1; cycle();
        check("t6_level", 32'(o_level), 32'h0);
        check("t6_valid", 32'(o_valid), 32'h0);
        check("t6_ovf", 32'(o_ovf), 32'h0);
        rst = 1'b0;
        wait_press(0, lat);
        check("t6_latency", 32'(lat), 32'd6);
        sw[0] = 1'b0; run(12);

        // Random switches, random Ready, occasional reset
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) sw = 4'($urandom);
            ready = 1'($urandom_range(0, 2) != 0);
            rst = 1'($urandom_range(0, 400) == 0);
            cycle();
        end
        rst = 1'b0;
        run(4);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
